// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic pipeline-stage register with stall, flush, NOP-gating
//               of invalid entries and saturating stall/bubble counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int              CTRL_W     = 13,
    parameter int              DATA_W     = 148,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter int              CLEAR_DATA = 1,
    parameter int              CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_load_bubble;
    logic              w_stall_hold;
    logic [DATA_W-1:0] w_bubble_data;

    // An invalid upstream entry is squashed exactly like a flush.
    assign w_load_bubble = flush | (~stall & ~valid_in);
    assign w_stall_hold  = stall & ~flush;

    generate
        if (CLEAR_DATA != 0) begin : g_clear_data
            assign w_bubble_data = '0;
        end else begin : g_keep_data
            assign w_bubble_data = r_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_ctrl       <= CTRL_NOP;
            r_data       <= '0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_load_bubble) begin
                r_valid <= 1'b0;
                r_ctrl  <= CTRL_NOP;
                r_data  <= w_bubble_data;
            end else if (!stall) begin
                r_valid <= 1'b1;
                r_ctrl  <= ctrl_in;
                r_data  <= data_in;
            end

            if (cnt_clr) begin
                r_stall_cnt  <= '0;
                r_bubble_cnt <= '0;
            end else begin
                if (w_stall_hold && (r_stall_cnt != c_CNT_MAX)) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
                if (w_load_bubble && (r_bubble_cnt != c_CNT_MAX)) begin
                    r_bubble_cnt <= r_bubble_cnt + 1'b1;
                end
            end
        end
    end

    assign valid_out  = r_valid;
    assign ctrl_out   = r_ctrl;
    assign data_out   = r_data;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Bench for pipe_stage_reg: a default build and a CLEAR_DATA=0,
//               CNT_W=3 build share one stimulus stream and one reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int CTRL_W = 13;
    localparam int DATA_W = 148;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              flush;
    logic              cnt_clr;
    logic              valid_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] data_in;

    logic              valid_a, valid_b;
    logic [CTRL_W-1:0] ctrl_a, ctrl_b;
    logic [DATA_W-1:0] data_a, data_b;
    logic [15:0]       scnt_a, bcnt_a;
    logic [2:0]        scnt_b, bcnt_b;

    int total;
    int bad;

    pipe_stage_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_NOP('0), .CLEAR_DATA(1), .CNT_W(16)
    ) u_dut_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
        .valid_out(valid_a), .ctrl_out(ctrl_a), .data_out(data_a),
        .stall_cnt(scnt_a), .bubble_cnt(bcnt_a)
    );

    pipe_stage_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_NOP('0), .CLEAR_DATA(0), .CNT_W(3)
    ) u_dut_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
        .valid_out(valid_b), .ctrl_out(ctrl_b), .data_out(data_b),
        .stall_cnt(scnt_b), .bubble_cnt(bcnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 = default build, index 1 = keep-data / 3-bit build.
    bit                m_valid [2];
    logic [CTRL_W-1:0] m_ctrl  [2];
    logic [DATA_W-1:0] m_data  [2];
    int                m_scnt  [2];
    int                m_bcnt  [2];
    bit                m_clear [2] = '{1'b1, 1'b0};
    int                m_max   [2] = '{65535, 7};

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_valid[i] = 0; m_ctrl[i] = '0; m_data[i] = '0;
                m_scnt[i] = 0;  m_bcnt[i] = 0;
            end else begin
                bit bubble;
                bit held;
                bubble = flush || (!stall && !valid_in);
                held   = stall && !flush;
                if (bubble) begin
                    m_valid[i] = 0;
                    m_ctrl[i]  = '0;
                    if (m_clear[i]) m_data[i] = '0;
                end else if (!held) begin
                    m_valid[i] = 1;
                    m_ctrl[i]  = ctrl_in;
                    m_data[i]  = data_in;
                end
                if (cnt_clr) begin
                    m_scnt[i] = 0;
                    m_bcnt[i] = 0;
                end else begin
                    if (held)   m_scnt[i] = (m_scnt[i] + 1 > m_max[i]) ? m_max[i] : m_scnt[i] + 1;
                    if (bubble) m_bcnt[i] = (m_bcnt[i] + 1 > m_max[i]) ? m_max[i] : m_bcnt[i] + 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("a.valid", DATA_W'(valid_a), DATA_W'(m_valid[0]));
        chk("a.ctrl",  DATA_W'(ctrl_a),  DATA_W'(m_ctrl[0]));
        chk("a.data",  data_a,           m_data[0]);
        chk("a.scnt",  DATA_W'(scnt_a),  DATA_W'(m_scnt[0]));
        chk("a.bcnt",  DATA_W'(bcnt_a),  DATA_W'(m_bcnt[0]));
        chk("b.valid", DATA_W'(valid_b), DATA_W'(m_valid[1]));
        chk("b.ctrl",  DATA_W'(ctrl_b),  DATA_W'(m_ctrl[1]));
        chk("b.data",  data_b,           m_data[1]);
        chk("b.scnt",  DATA_W'(scnt_b),  DATA_W'(m_scnt[1]));
        chk("b.bcnt",  DATA_W'(bcnt_b),  DATA_W'(m_bcnt[1]));
    endtask

    // Inputs are changed 1 time unit after an edge and outputs are sampled there.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk_model();
    endtask

    task automatic drive(input bit r, input bit s, input bit f, input bit c, input bit v,
                         input logic [CTRL_W-1:0] ct, input logic [DATA_W-1:0] d);
        reset = r; stall = s; flush = f; cnt_clr = c; valid_in = v; ctrl_in = ct; data_in = d;
    endtask

    typedef struct {
        bit                rst, stl, flu, clr, vin;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        bit                e_valid;
        logic [CTRL_W-1:0] e_ctrl;
        logic [DATA_W-1:0] e_data;
        int                e_scnt, e_bcnt;
    } vec_t;

    vec_t vecs [12];
    logic [DATA_W-1:0] ones;
    logic [159:0]      rnd;

    initial begin
        total = 0;
        bad   = 0;
        ones  = '1;
        drive(1, 0, 0, 0, 0, '0, '0);

        // Expected values are for the default (CLEAR_DATA=1, CNT_W=16) build.
        vecs[0]  = '{1,0,0,0,1, 13'h1FFF, ones,       0, 13'h000, '0,         0, 0};
        vecs[1]  = '{1,0,0,0,1, 13'h1FFF, ones,       0, 13'h000, '0,         0, 0};
        vecs[2]  = '{0,0,0,0,1, 13'h0A5,  148'hDEAD,  1, 13'h0A5, 148'hDEAD,  0, 0};
        vecs[3]  = '{0,1,0,0,1, 13'h111,  148'hBEEF,  1, 13'h0A5, 148'hDEAD,  1, 0};
        vecs[4]  = '{0,1,0,0,1, 13'h111,  148'hBEEF,  1, 13'h0A5, 148'hDEAD,  2, 0};
        vecs[5]  = '{0,1,0,0,1, 13'h111,  148'hBEEF,  1, 13'h0A5, 148'hDEAD,  3, 0};
        vecs[6]  = '{0,1,1,0,1, 13'h111,  148'hBEEF,  0, 13'h000, '0,         3, 1};
        vecs[7]  = '{0,0,0,0,1, 13'h123,  148'hCAFE,  1, 13'h123, 148'hCAFE,  3, 1};
        vecs[8]  = '{0,0,0,0,0, 13'h1FFF, 148'h5555,  0, 13'h000, '0,         3, 2};
        vecs[9]  = '{0,0,0,1,1, 13'h007,  148'h77,    1, 13'h007, 148'h77,    0, 0};
        vecs[10] = '{0,1,0,1,1, 13'h0FF,  148'hFF,    1, 13'h007, 148'h77,    0, 0};
        vecs[11] = '{0,0,1,1,1, 13'h0FF,  148'hFF,    0, 13'h000, '0,         0, 0};

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].flu, vecs[i].clr, vecs[i].vin,
                  vecs[i].ctrl, vecs[i].data);
            step();
            chk($sformatf("vec%0d.valid", i), DATA_W'(valid_a), DATA_W'(vecs[i].e_valid));
            chk($sformatf("vec%0d.ctrl", i),  DATA_W'(ctrl_a),  DATA_W'(vecs[i].e_ctrl));
            chk($sformatf("vec%0d.data", i),  data_a,           vecs[i].e_data);
            chk($sformatf("vec%0d.scnt", i),  DATA_W'(scnt_a),  DATA_W'(vecs[i].e_scnt));
            chk($sformatf("vec%0d.bcnt", i),  DATA_W'(bcnt_a),  DATA_W'(vecs[i].e_bcnt));
            if (i == 8)
                chk("keepdata.b", data_b, 148'hCAFE);
        end

        // Saturation on the 3-bit build, then clear beating a same-cycle stall.
        drive(0, 0, 0, 1, 1, 13'h042, 148'h4242);
        step();
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 0, 0, 1, 13'h1AB, 148'h1);
            step();
        end
        chk("sat.b.scnt", DATA_W'(scnt_b), DATA_W'(3'd7));
        chk("sat.a.scnt", DATA_W'(scnt_a), DATA_W'(16'd10));
        drive(0, 1, 0, 1, 1, 13'h1AB, 148'h1);
        step();
        chk("satclr.b.scnt", DATA_W'(scnt_b), '0);
        chk("satclr.ctrl",   DATA_W'(ctrl_a), DATA_W'(13'h042));

        // Reset pulsed in the middle of a stall/flush sequence.
        drive(0, 1, 1, 0, 1, 13'h055, 148'h55);
        step();
        drive(0, 0, 0, 0, 1, 13'h066, 148'h66);
        step();
        drive(1, 1, 1, 0, 1, 13'h077, 148'h77);
        step();
        chk("rstmid.valid", DATA_W'(valid_a), '0);
        chk("rstmid.bcnt",  DATA_W'(bcnt_a),  '0);
        chk("rstmid.data.b", data_b, '0);
        drive(0, 0, 0, 0, 1, 13'h0BC, 148'hABCDEF);
        step();
        chk("postrst.valid", DATA_W'(valid_a), DATA_W'(1'b1));
        chk("postrst.data",  data_a, 148'hABCDEF);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 3) != 0), CTRL_W'($urandom()), rnd[DATA_W-1:0]);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register that replaces the per-boundary hand-written registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a control bundle and a data bundle, plus a valid bit. It supports stall (hold), flush (bubble insertion) and NOP-gating of invalid entries. It also keeps saturating stall and bubble counters for hazard-unit profiling. One instance sits at each stage boundary of the 5-stage MIPS pipeline.

## Interface
- `CTRL_W`, 13: control bundle width; 13 matches the ID/EX control set.
- `DATA_W`, 148: data bundle width; 148 matches the ID/EX operands, register IDs, shamt and PC+4.
- `CTRL_NOP`, 0 (CTRL_W bits): control value driven for any bubble or invalid entry.
- `CLEAR_DATA`, 1: 1 zeroes `data_out` on a bubble; 0 keeps the previous data on a bubble.
- `CNT_W`, 16: width of each performance counter.
- `clk`, input, 1: clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `stall`, input, 1: hold the current contents.
- `flush`, input, 1: load a bubble.
- `cnt_clr`, input, 1: synchronous clear of both counters.
- `valid_in`, input, 1: the upstream stage holds a real instruction.
- `ctrl_in`, input, CTRL_W: control bundle from the upstream stage.
- `data_in`, input, DATA_W: data bundle from the upstream stage.
- `valid_out`, output, 1: the registered entry is a real instruction.
- `ctrl_out`, output, CTRL_W: registered control bundle.
- `data_out`, output, DATA_W: registered data bundle.
- `stall_cnt`, output, CNT_W: count of stall cycles.
- `bubble_cnt`, output, CNT_W: count of bubbles loaded.

## Operation
- Priority on each rising edge is reset > flush > stall > load.
- **Reset:**
  - `valid_out`=0, `ctrl_out`=CTRL_NOP, `data_out`=0.
  - `stall_cnt`=0, `bubble_cnt`=0.
- **Flush (bubble):**
  - `valid_out`=0, `ctrl_out`=CTRL_NOP.
  - `data_out`=0 if CLEAR_DATA=1; otherwise unchanged.
  - Flush overrides a simultaneous stall, so a load-use bubble can be inserted while upstream stages stall.
- **Stall (flush=0):** all of `valid_out`, `ctrl_out` and `data_out` hold their values.
- **Load, valid_in=1:** `valid_out`=1, `ctrl_out`=`ctrl_in`, `data_out`=`data_in`.
- **Load, valid_in=0:**
  - Treated as a bubble: `valid_out`=0, `ctrl_out`=CTRL_NOP.
  - `data_out` follows the CLEAR_DATA rule.
  - Consequence: an invalid entry never carries write or memory enables downstream.
- **Counters:**
  - `stall_cnt` +1 on each edge with stall=1, flush=0, reset=0.
  - `bubble_cnt` +1 on each edge that loads a bubble, either by flush or by a load with valid_in=0. Reset does not count as a bubble.
  - Both counters saturate at 2^CNT_W−1; they never wrap.
  - `cnt_clr`=1 zeroes both counters and overrides a same-cycle increment.
  - `cnt_clr` does not affect the pipeline contents.
- No combinational path from any input to any output.
- The counters are the only arithmetic, each CNT_W bits wide with unsigned saturation.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Stall held for k cycles: outputs are constant for those k edges, and `stall_cnt` rises by k.
- Reset asserted mid-stream: outputs go to reset values on the next edge, whatever stall or flush are doing. The first load is possible on the edge after reset deasserts.
- flush and stall together for m cycles: the register loads m bubbles. `bubble_cnt` rises by m; `stall_cnt` is unchanged.
- Saturated counter with cnt_clr=1: the counter reads 0 on the next edge.

## Test plan
- **Reset:** reset=1 for 2 cycles with `ctrl_in`=0x1FFF, `data_in` all-ones, valid_in=1 → valid_out=0, ctrl_out=0, data_out=0, both counters 0.
- **Load then stall:**
  - Stimulus: load valid_in=1, ctrl_in=0x0A5, data_in=0x…DEAD; then stall=1 for 3 cycles with ctrl_in=0x111.
  - Required: outputs stay 0x0A5 / 0x…DEAD with valid_out=1, and stall_cnt=3.
- **Flush beats stall:** stall=1 and flush=1 for 1 cycle → valid_out=0, ctrl_out=CTRL_NOP, data_out=0, bubble_cnt+1, stall_cnt unchanged.
- **Invalid load gating:**
  - Stimulus: valid_in=0, ctrl_in=0x1FFF.
  - Required: ctrl_out=0. With CLEAR_DATA=0 build, data_out keeps the prior value.
- **Counter saturation:** CNT_W=3, stall held 10 cycles → stall_cnt reaches 7 and stays at 7. Then cnt_clr=1 with stall=1 → stall_cnt=0 on the next edge.
- **Reset mid-stall:** reset pulsed during a stall/flush sequence → reset values on the next edge, counters 0. A load on the following edge passes data through with valid_out=1.
